// File: rtl/ahb_gpio_param.sv
// AHB-Lite GPIO slave with per-pin direction, input synchroniser and
// edge-detect interrupts (write-1-to-clear status).
module ahb_gpio_param #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    input  logic [WIDTH-1:0] GPIOIN,
    output logic [WIDTH-1:0] GPIOOUT,
    output logic [WIDTH-1:0] GPIOOE,
    output logic             GPIOIRQ
);

    localparam logic [2:0] A_DOUT = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_DIN  = 3'd2;
    localparam logic [2:0] A_IEN  = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;
    localparam logic [2:0] A_ESEL = 3'd5;

    logic             dp_valid;
    logic             dp_write;
    logic [2:0]       dp_addr;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_status;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c;
    logic             wr;
    logic             unused;

    assign s     = sync_q[SYNC_STAGES-1];
    assign wdata = HWDATA[WIDTH-1:0];
    assign wr    = dp_valid & dp_write;

    assign edge_hit = ~dir & ((~edge_sel & s & ~p) | (edge_sel & ~s & p));
    assign w1c      = (wr && dp_addr == A_STAT) ? wdata : '0;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 3'd0;
        end else begin
            dp_valid <= HSEL & HREADY & HTRANS[1];
            if (HSEL & HREADY & HTRANS[1]) begin
                dp_addr  <= HADDR[4:2];
                dp_write <= HWRITE;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            p <= '0;
        end else begin
            sync_q[0] <= GPIOIN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            p <= s;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_out   <= '0;
            dir        <= '0;
            irq_en     <= '0;
            irq_status <= '0;
            edge_sel   <= '0;
        end else begin
            // a fresh edge overrides a same-cycle clear of that bit
            irq_status <= (irq_status & ~w1c) | edge_hit;
            if (wr) begin
                case (dp_addr)
                    A_DOUT:  data_out <= wdata;
                    A_DIR:   dir      <= wdata;
                    A_IEN:   irq_en   <= wdata;
                    A_ESEL:  edge_sel <= wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        case (dp_addr)
            A_DOUT:  HRDATA[WIDTH-1:0] = data_out;
            A_DIR:   HRDATA[WIDTH-1:0] = dir;
            A_DIN:   HRDATA[WIDTH-1:0] = s;
            A_IEN:   HRDATA[WIDTH-1:0] = irq_en;
            A_STAT:  HRDATA[WIDTH-1:0] = irq_status;
            A_ESEL:  HRDATA[WIDTH-1:0] = edge_sel;
            default: HRDATA = '0;
        endcase
    end

    assign HREADYOUT = 1'b1;
    assign GPIOOUT   = data_out;
    assign GPIOOE    = dir;
    assign GPIOIRQ   = |(irq_status & irq_en);
    assign unused    = ^{HADDR, HTRANS[0], HWDATA};

endmodule

// File: tb/tb_ahb_gpio_param.sv
// Randomised scoreboard bench for ahb_gpio_param against a pin/register
// level reference model, plus a directed check of a 32-pin, 3-stage build.
module tb_ahb_gpio_param;

    localparam int W = 16;
    localparam int S = 2;

    localparam logic [31:0] A_DOUT = 32'h00;
    localparam logic [31:0] A_DIR  = 32'h04;
    localparam logic [31:0] A_DIN  = 32'h08;
    localparam logic [31:0] A_IEN  = 32'h0C;
    localparam logic [31:0] A_STAT = 32'h10;
    localparam logic [31:0] A_ESEL = 32'h14;
    localparam logic [31:0] A_R18  = 32'h18;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          HSEL, HWRITE, HREADY;
    logic [31:0]   HADDR, HWDATA, HRDATA;
    logic [1:0]    HTRANS;
    logic          HREADYOUT, GPIOIRQ;
    logic [W-1:0]  GPIOIN, GPIOOUT, GPIOOE;

    logic          b_hsel, b_hwrite, b_hready, b_hreadyout, b_irq;
    logic [31:0]   b_haddr, b_hwdata, b_hrdata, b_gpioin, b_gpioout, b_gpiooe;
    logic [1:0]    b_htrans;

    always #5 HCLK = ~HCLK;

    ahb_gpio_param #(.WIDTH(W), .SYNC_STAGES(S)) u_dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .GPIOIN(GPIOIN),
        .GPIOOUT(GPIOOUT), .GPIOOE(GPIOOE), .GPIOIRQ(GPIOIRQ)
    );

    ahb_gpio_param #(.WIDTH(32), .SYNC_STAGES(3)) u_wide (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(b_hsel), .HADDR(b_haddr),
        .HTRANS(b_htrans), .HWRITE(b_hwrite), .HWDATA(b_hwdata),
        .HREADY(b_hready), .HRDATA(b_hrdata), .HREADYOUT(b_hreadyout),
        .GPIOIN(b_gpioin), .GPIOOUT(b_gpioout), .GPIOOE(b_gpiooe),
        .GPIOIRQ(b_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // Reference model: registers as plain variables, pins as a delay line
    // of sampled GPIOIN values (newest first).
    logic [W-1:0] m_dout, m_dir, m_ien, m_st, m_es;
    logic [W-1:0] hist[$];
    logic [31:0]  exp_q[$];
    bit           m_pv, m_pw, rd_dp;
    bit [2:0]     m_pa;

    function automatic logic [31:0] m_read(input bit [2:0] a);
        logic [W-1:0] v;
        case (a)
            3'd0: v = m_dout;
            3'd1: v = m_dir;
            3'd2: v = hist[S-1];
            3'd3: v = m_ien;
            3'd4: v = m_st;
            3'd5: v = m_es;
            default: v = '0;
        endcase
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_dout = '0; m_dir = '0; m_ien = '0; m_st = '0; m_es = '0;
        m_pv = 0; m_pw = 0; m_pa = 0; rd_dp = 0;
        hist.delete();
        exp_q.delete();
        for (int i = 0; i <= S; i++) hist.push_back('0);
    endtask

    task automatic model_step();
        logic [W-1:0] sv, pv, ev, wd;
        sv = hist[S-1];
        pv = hist[S];
        ev = '0;
        for (int i = 0; i < W; i++)
            if (!m_dir[i])
                ev[i] = m_es[i] ? (!sv[i] && pv[i]) : (sv[i] && !pv[i]);
        wd = HWDATA[W-1:0];
        if (m_pv && m_pw) begin
            case (m_pa)
                3'd0: m_dout = wd;
                3'd1: m_dir  = wd;
                3'd3: m_ien  = wd;
                3'd4: m_st   = m_st & ~wd;
                3'd5: m_es   = wd;
                default: ;
            endcase
        end
        m_st = m_st | ev;
        hist.push_front(GPIOIN);
        void'(hist.pop_back());
        m_pv = HSEL && HREADY && HTRANS[1];
        if (m_pv) begin
            m_pa = HADDR[4:2];
            m_pw = HWRITE;
        end
        rd_dp = m_pv && !m_pw;
        if (rd_dp) exp_q.push_back(m_read(m_pa));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge HCLK or posedge HRESET);
            if (HRESET) model_reset();
            else model_step();
        end
    end

    // Monitor: pins every cycle, read data whenever a read data phase is up
    initial begin
        forever begin
            @(negedge HCLK);
            if (!HRESET) begin
                chk("gpioout", 32'(GPIOOUT), 32'(m_dout));
                chk("gpiooe", 32'(GPIOOE), 32'(m_dir));
                chk("gpioirq", 32'(GPIOIRQ), 32'(|(m_st & m_ien)));
                chk("hreadyout", 32'(HREADYOUT), 32'd1);
                if (rd_dp) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: read with no expected entry");
                    end else begin
                        chk("hrdata", HRDATA, exp_q.pop_front());
                    end
                end
            end
        end
    end

    logic [31:0] nxt_wdata = '0;
    bit          prev_v = 0;

    task automatic bus_op(input bit v, input bit w, input logic [31:0] a,
                          input logic [31:0] d);
        @(negedge HCLK);
        HWDATA = nxt_wdata;
        HSEL   = v;
        HTRANS = v ? 2'b10 : 2'b00;
        HWRITE = w;
        HADDR  = a;
        HREADY = 1'b1;
        if (!v && !prev_v) begin
            // unaccepted variants: selected but IDLE, or NONSEQ without HREADY
            HSEL   = 1'($urandom_range(0, 1));
            HTRANS = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            HREADY = (HTRANS[1] && HSEL) ? 1'b0 : 1'b1;
        end
        nxt_wdata = d;
        prev_v = v;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_op(1, 1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        bus_op(1, 0, a, $urandom());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_op(0, 0, 32'h0, $urandom());
    endtask

    initial begin
        logic [31:0] ra, rdat;
        HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HWDATA = 0;
        HREADY = 1; GPIOIN = '0;
        b_hsel = 0; b_htrans = 0; b_hwrite = 0; b_haddr = 0;
        b_hwdata = 0; b_hready = 1; b_gpioin = 0;
        repeat (3) @(negedge HCLK);
        HRESET = 0;
        #1;
        chk("rst_gpioout", 32'(GPIOOUT), 32'h0);
        chk("rst_gpiooe", 32'(GPIOOE), 32'h0);
        chk("rst_irq", 32'(GPIOIRQ), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);

        // 32-pin, 3-stage instance: directed
        @(negedge HCLK);
        b_hsel = 1; b_htrans = 2'b10; b_hwrite = 1; b_haddr = A_IEN;
        @(negedge HCLK);
        b_hwdata = 32'h8000_0000; b_haddr = A_DOUT;
        @(negedge HCLK);
        b_hwdata = 32'hFFFF_FFFF; b_haddr = A_DIN; b_hwrite = 0;
        @(negedge HCLK);
        b_hsel = 0; b_htrans = 2'b00;
        chk("wide_gpioout", b_gpioout, 32'hFFFF_FFFF);
        chk("wide_din0", b_hrdata, 32'h0);
        b_gpioin = 32'h8000_0000;
        for (int k = 1; k <= 4; k++) begin
            @(negedge HCLK);
            chk($sformatf("wide_din_e%0d", k), b_hrdata,
                (k >= 3) ? 32'h8000_0000 : 32'h0);
            chk($sformatf("wide_irq_e%0d", k), 32'(b_irq),
                (k >= 4) ? 32'h1 : 32'h0);
        end

        // reset in the data phase of a DATA_OUT write
        wr(A_DOUT, 32'h0000_00AB);
        idle(1);
        #2 HRESET = 1;
        #1;
        chk("midrst_gpioout", 32'(GPIOOUT), 32'h0);
        chk("midrst_gpiooe", 32'(GPIOOE), 32'h0);
        chk("midrst_irq", 32'(GPIOIRQ), 32'h0);
        chk("midrst_hrdata", HRDATA, 32'h0);
        chk("wide_rst_out", b_gpioout, 32'h0);
        @(negedge HCLK);
        HRESET = 0;
        HSEL = 0; HTRANS = 0; nxt_wdata = 0; prev_v = 0;
        for (int i = 0; i < 8; i++) rd(32'(i * 4));
        idle(2);

        wr(A_DIR, 32'h0000_00FF);
        wr(A_DOUT, 32'h0000_1234);
        rd(A_DOUT);
        idle(2);

        bus_op(0, 0, 0, 0);
        GPIOIN = 16'h0A50;
        idle(3);
        rd(A_DIN);
        wr(A_R18, 32'hDEAD_BEEF);
        rd(A_R18);
        rd(32'h1C);
        idle(2);

        wr(A_DIR, 32'h0);
        wr(A_ESEL, 32'h0);
        wr(A_IEN, 32'h0010);
        bus_op(0, 0, 0, 0);
        GPIOIN = '0;
        idle(4);
        wr(A_STAT, 32'hFFFF);
        bus_op(0, 0, 0, 0);
        GPIOIN = 16'h0010;
        idle(4);
        rd(A_STAT);
        wr(A_STAT, 32'h0010);
        rd(A_STAT);
        bus_op(0, 0, 0, 0);
        GPIOIN = '0;
        idle(4);
        rd(A_STAT);
        idle(1);

        // falling edge on bit0 collides with its W1C write
        wr(A_ESEL, 32'h0001);
        bus_op(0, 0, 0, 0);
        GPIOIN = 16'h0001;
        idle(4);
        bus_op(0, 0, 0, 0);
        GPIOIN = 16'h0000;
        wr(A_STAT, 32'h0001);
        rd(A_STAT);
        wr(A_DIR, 32'h0020);
        for (int i = 0; i < 4; i++) begin
            bus_op(0, 0, 0, 0);
            GPIOIN = GPIOIN ^ 16'h0020;
            idle(3);
        end
        rd(A_STAT);
        idle(2);

        for (int n = 0; n < 800; n++) begin
            ra = ($urandom() & 32'hFFFF_FFE0) | 32'($urandom_range(0, 7) * 4);
            rdat = $urandom();
            if ($urandom_range(0, 9) < 7)
                bus_op(1, 1'($urandom_range(0, 1)), ra, rdat);
            else
                bus_op(0, 0, ra, rdat);
            if ($urandom_range(0, 3) == 0)
                GPIOIN = GPIOIN ^ W'($urandom());
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
